// File: rtl/i2s_target_port.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_target_port
//  Description : I2S target endpoint. Oversamples externally supplied
//                SCLK/LRCLK, deserializes received words per channel and
//                serializes per-channel transmit words back to the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_target_port #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i2s_sclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_sdin,
    output logic                i2s_sdout,
    output logic [SAMPLE_W-1:0] rx_data,
    output logic                rx_ch,
    output logic                rx_vld,
    input  logic [SAMPLE_W-1:0] tx_data0,
    input  logic [SAMPLE_W-1:0] tx_data1,
    output logic [1:0]          tx_ack,
    input  logic                err_clr,
    output logic                locked,
    output logic                frame_err
);

    localparam logic [5:0] c_cnt_max  = 6'd63;
    localparam logic [5:0] c_slot_w   = 6'(SLOT_W);
    localparam logic [5:0] c_sample_w = 6'(SAMPLE_W);

    // Synchronizers and SCLK edge detection
    logic [1:0]          r_sclk_sync;
    logic [1:0]          r_lr_sync;
    logic [1:0]          r_sd_sync;
    logic                r_sclk_dly;

    // Framing state
    logic                r_primed;
    logic                r_prev_lr;
    logic [5:0]          r_bit_cnt;
    logic                r_locked;
    logic                r_frame_err;

    // Datapath
    logic [SAMPLE_W-1:0] r_rx_shift;
    logic [SAMPLE_W-1:0] r_rx_data;
    logic                r_rx_ch;
    logic                r_rx_vld;
    logic [SAMPLE_W-1:0] r_tx_shift;
    logic [1:0]          r_tx_ack;
    logic                r_sdout;

    logic                w_sclk_rise;
    logic                w_sclk_fall;
    logic                w_lr;
    logic                w_sd;
    logic                w_new_slot;
    logic                w_same_slot;
    logic                w_rx_bit;
    logic                w_rx_last;

    always_comb begin
        w_sclk_rise = r_sclk_sync[1] & ~r_sclk_dly;
        w_sclk_fall = ~r_sclk_sync[1] & r_sclk_dly;
        w_lr        = r_lr_sync[1];
        w_sd        = r_sd_sync[1];
        // The first rise after reset only records LRCLK, so a reset in the
        // middle of a slot can never be mistaken for a slot boundary.
        w_new_slot  = w_sclk_rise & r_primed & (w_lr != r_prev_lr);
        w_same_slot = w_sclk_rise & r_primed & (w_lr == r_prev_lr);
        w_rx_bit    = w_same_slot & r_locked & (r_bit_cnt != 6'd0)
                      & (r_bit_cnt <= c_sample_w);
        w_rx_last   = w_same_slot & r_locked & (r_bit_cnt == c_sample_w);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_sync <= 2'b00;
            r_lr_sync   <= 2'b00;
            r_sd_sync   <= 2'b00;
            r_sclk_dly  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i2s_sclk};
            r_lr_sync   <= {r_lr_sync[0], i2s_lrclk};
            r_sd_sync   <= {r_sd_sync[0], i2s_sdin};
            r_sclk_dly  <= r_sclk_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_primed    <= 1'b0;
            r_prev_lr   <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_sclk_rise && !r_primed) begin
                r_primed  <= 1'b1;
                r_prev_lr <= w_lr;
            end
            if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_new_slot) begin
                r_prev_lr <= w_lr;
                r_bit_cnt <= 6'd1;
                r_locked  <= 1'b1;
                if (r_locked && (r_bit_cnt != c_slot_w)) begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_same_slot && (r_bit_cnt != c_cnt_max)) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_ch    <= 1'b0;
            r_rx_vld   <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            if (w_rx_bit) begin
                r_rx_shift <= {r_rx_shift[SAMPLE_W-2:0], w_sd};
            end
            if (w_rx_last) begin
                r_rx_data <= {r_rx_shift[SAMPLE_W-2:0], w_sd};
                r_rx_ch   <= w_lr;
                r_rx_vld  <= 1'b1;
            end
        end
    end

    // Transmit word is loaded at the slot-start rise and shifted out on the
    // following falls, giving the one-bit I2S delay as seen by the controller.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_shift <= '0;
            r_tx_ack   <= 2'b00;
            r_sdout    <= 1'b0;
        end else begin
            r_tx_ack <= 2'b00;
            if (w_new_slot) begin
                r_tx_shift <= w_lr ? tx_data1 : tx_data0;
                r_tx_ack   <= w_lr ? 2'b10 : 2'b01;
            end else if (w_sclk_fall && r_locked) begin
                r_sdout    <= r_tx_shift[SAMPLE_W-1];
                r_tx_shift <= {r_tx_shift[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    assign i2s_sdout = r_sdout;
    assign rx_data   = r_rx_data;
    assign rx_ch     = r_rx_ch;
    assign rx_vld    = r_rx_vld;
    assign tx_ack    = r_tx_ack;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/i2s_target_port.md
Name: i2s_target_port

Overview:
- Synthesizable I2S target (codec-side) endpoint. It is the far end of the I2S link that the CBI980 controller drives.
- Consumes externally generated SCLK/LRCLK and deserializes the controller's serial data into per-channel samples.
- Serializes per-channel samples back toward the controller.
- Used as an on-chip loopback/codec stand-in and as the link partner in CBI980 system benches.

Parameters:
- SAMPLE_W, 24, data bits per channel word, MSB first.
- SLOT_W, 32, SCLK periods per LRCLK half-frame. Legal range SAMPLE_W+1..63.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i2s_sclk  in  1  bit clock from controller; asynchronous to clk.
- i2s_lrclk  in  1  word select; 0 = channel 0 (left), 1 = channel 1 (right).
- i2s_sdin  in  1  serial data from controller.
- i2s_sdout  out  1  serial data to controller.
- rx_data  out  SAMPLE_W  last received word.
- rx_ch  out  1  channel of rx_data.
- rx_vld  out  1  one-clk pulse: rx_data/rx_ch valid.
- tx_data0  in  SAMPLE_W  next word for channel 0.
- tx_data1  in  SAMPLE_W  next word for channel 1.
- tx_ack  out  2  one-clk pulse per channel: tx_dataN captured.
- err_clr  in  1  clears frame_err.
- locked  out  1  a valid LRCLK edge has been seen since reset.
- frame_err  out  1  sticky: a half-frame length was not SLOT_W.

Behaviour:
- Reset (rstn=0, async): i2s_sdout=0, rx_data=0, rx_ch=0, rx_vld=0, tx_ack=0, locked=0, frame_err=0, bit_cnt=0, shift registers 0. Synchronizer flops are also cleared.
- Input sync: sclk, lrclk and sdin each pass through 2 flops. A third sclk flop gives the edge detectors sclk_rise and sclk_fall, each a one-clk pulse.
  - Requirement: clk >= 8x SCLK. Sync latency is 3 clk.
- On sclk_rise:
  - Sample L = synced lrclk and D = synced sdin. Keep prev_L.
  - If L != prev_L: start a new slot. bit_cnt <= 1, so the current edge is index 0, the one-bit I2S delay slot; D is discarded.
    - If locked=1 and the old bit_cnt != SLOT_W, set frame_err.
    - Set locked <= 1.
    - Load tx shift register from tx_data[L] and pulse tx_ack[L] in the same clk.
  - Else: bit_cnt <= bit_cnt+1, saturating at 63.
  - At indices 1..SAMPLE_W with locked=1, shift D into rx_shift MSB-first.
  - At index SAMPLE_W: rx_data <= completed word (including D), rx_ch <= L, rx_vld=1 for exactly one clk.
    - The pulse occurs in the clk after the sclk_rise that sampled the LSB.
- On sclk_fall (locked=1): i2s_sdout <= tx_shift MSB, then shift left, zero-filled.
  - The first falling edge after the slot start drives the MSB; the controller samples it on the next rising edge, per I2S.
  - After SAMPLE_W bits, sdout stays 0 until the next slot.
- Before lock:
  - No rx_vld, no tx_ack, sdout=0.
  - The first LRCLK edge after reset locks without checking frame_err.
- Channel-0/1 slots alternate. There is no rx buffering: the consumer must take rx_data within one half-frame.
- frame_err clears only via err_clr (sync, 1 clk). If err_clr and a new error occur in the same clk, the set wins.
- LRCLK stuck: bit_cnt saturates at 63 with no spurious rx_vld/tx_ack. On the next edge, frame_err is set.
- Reset mid-frame: all state clears immediately. Operation resumes only after the next LRCLK edge (locked), so a partial word is never emitted.
- SCLK stopped: outputs hold; no pulses.

Test Plan:
- Reset: rstn=0 while SCLK runs -> sdout=0, rx_vld=0, tx_ack=0, locked=0. Release -> first LRCLK edge sets locked, frame_err stays 0.
- RX: controller sends ch0=24'hA5F00F, ch1=24'h123456 at SLOT_W=32, SCLK=clk/8.
  - Expect rx_vld with (rx_ch=0, 24'hA5F00F) then (rx_ch=1, 24'h123456), one pulse each, every frame.
- TX: tx_data0=24'hC0FFEE, tx_data1=24'h800001 -> the bench I2S receiver decodes the same words.
  - tx_ack[0] and tx_ack[1] pulse once per frame, each on its own slot start.
  - sdout is 0 on bits 25..31 of each slot.
- Loopback: sdout wired to the controller's sdin for 100 frames with incrementing samples -> all words match, frame_err=0.
- Framing error: one half-frame shortened to 30 SCLKs -> frame_err=1 at that LRCLK edge and stays 1. err_clr pulse -> 0. Next frames are normal.
- Mid-frame reset at bit 10 of a ch1 slot -> no rx_vld for that slot. Re-lock on the next LRCLK edge, then correct data resumes.
